// File: rtl/ps2_key_matrix_pkg.sv
// rtl/ps2_key_matrix_pkg.sv - shared types, entry layout and scan codes for ps2_key_matrix
// Map entry layout, LSB first: col[CW-1:0], row[RW-1:0], lock, valid.
// RW/CW are clog2 of the matrix geometry with a floor of one bit.
package ps2_key_matrix_pkg;

    // Scan codes referenced by the built-in map: {extended, code}.
    localparam logic [8:0] CAPS   = 9'h058;
    localparam logic [8:0] LSHIFT = 9'h012;
    localparam logic [8:0] ENTER  = 9'h05A;
    localparam logic [8:0] KEY_A  = 9'h01C;
    localparam logic [8:0] KEY_S  = 9'h01B;

    localparam int ENT_COL_LSB = 0;

    // Geometry-independent entry; row/col are wide enough for 16x16.
    typedef struct packed {
        logic       valid;
        logic       lock;
        logic [3:0] row;
        logic [3:0] col;
    } kmx_entry_t;

    function automatic int clog2min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int entry_w(input int rows, input int cols);
        return 2 + clog2min1(rows) + clog2min1(cols);
    endfunction

    function automatic int ent_row_lsb(input int cols);
        return clog2min1(cols);
    endfunction

    function automatic int ent_lock_bit(input int rows, input int cols);
        return clog2min1(rows) + clog2min1(cols);
    endfunction

    function automatic int ent_valid_bit(input int rows, input int cols);
        return clog2min1(rows) + clog2min1(cols) + 1;
    endfunction

    function automatic kmx_entry_t mk_entry(input logic lock, input logic [3:0] row,
                                            input logic [3:0] col);
        kmx_entry_t e;
        e.valid = 1'b1;
        e.lock  = lock;
        e.row   = row;
        e.col   = col;
        return e;
    endfunction

endpackage

// File: rtl/kmx_map_ram.sv
// rtl/kmx_map_ram.sv - scan-code map store with registered read
// Ports: clk_sys, reset; rd_addr -> rd_data (one-cycle latency);
//        we/wr_addr/wr_data remap write port.
// KMX_REMAP_EN defined: dual-port, read-first RAM; written addresses override
//   the built-in image until the next reset.
// KMX_REMAP_EN undefined: ROM holding the built-in image, write port ignored.
// INIT_FILE names the power-up image; an empty name selects a blank map.
module kmx_map_ram
    import ps2_key_matrix_pkg::*;
#(
    parameter int    ROWS      = 8,
    parameter int    COLS      = 8,
    parameter int    CODE_W    = 9,
    parameter string INIT_FILE = "keymap_default.mif"
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic [CODE_W-1:0]              rd_addr,
    output logic [entry_w(ROWS,COLS)-1:0]  rd_data,
    input  logic                           we,
    input  logic [CODE_W-1:0]              wr_addr,
    input  logic [entry_w(ROWS,COLS)-1:0]  wr_data
);
    localparam int RW = clog2min1(ROWS);
    localparam int CW = clog2min1(COLS);
    localparam int EW = entry_w(ROWS, COLS);
    localparam bit BLANK_MAP = (INIT_FILE == "");

    function automatic logic [EW-1:0] pack_entry(input kmx_entry_t e);
        return {e.valid, e.lock, e.row[RW-1:0], e.col[CW-1:0]};
    endfunction

    function automatic kmx_entry_t default_map(input logic [CODE_W-1:0] code);
        kmx_entry_t e;
        e = '0;
        if (!BLANK_MAP) begin
            case (code)
                CODE_W'(KEY_A):  e = mk_entry(1'b0, 4'd5, 4'd0);
                CODE_W'(KEY_S):  e = mk_entry(1'b0, 4'd5, 4'd1);
                CODE_W'(CAPS):   e = mk_entry(1'b1, 4'd4, 4'd7);
                CODE_W'(LSHIFT): e = mk_entry(1'b0, 4'd0, 4'd7);
                CODE_W'(ENTER):  e = mk_entry(1'b0, 4'd1, 4'd6);
                default:         e = '0;
            endcase
        end
        return e;
    endfunction

`ifdef KMX_REMAP_EN
    logic [EW-1:0]          mem [2**CODE_W];
    logic [2**CODE_W-1:0]   ovr_q;

    always_ff @(posedge clk_sys) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_sys) begin
        if (reset)   ovr_q <= '0;
        else if (we) ovr_q[wr_addr] <= 1'b1;
    end

    // Old mem/ovr values are sampled, so a same-cycle write reads first.
    always_ff @(posedge clk_sys) begin
        rd_data <= ovr_q[rd_addr] ? mem[rd_addr] : pack_entry(default_map(rd_addr));
    end
`else
    logic unused_wr_port;
    assign unused_wr_port = ^{reset, we, wr_addr, wr_data};

    always_ff @(posedge clk_sys) begin
        rd_data <= pack_entry(default_map(rd_addr));
    end
`endif

endmodule

// File: rtl/ps2_key_matrix.sv
// rtl/ps2_key_matrix.sv - PS/2 event to ROWSxCOLS keyboard matrix engine
// Ports: clk_sys, reset (sync, active-high); ps2_key toggle-style event;
//        ext_keys_i OR-merged sources; release_all_i; sel_n_i row strobes;
//        col_n_o column returns; lock_o lock states; held_cnt_o popcount;
//        map_we_i/map_addr_i/map_data_i remap port (KMX_REMAP_EN only).
// Pipeline: S0 edge detect/capture, S1 map read, S2 apply to matrix.
module ps2_key_matrix
    import ps2_key_matrix_pkg::*;
#(
    parameter int    ROWS      = 8,
    parameter int    COLS      = 8,
    parameter int    CODE_W    = 9,
    parameter string INIT_FILE = "keymap_default.mif"
) (
    input  logic                              clk_sys,
    input  logic                              reset,
    input  logic [10:0]                       ps2_key,
    input  logic [ROWS*COLS-1:0]              ext_keys_i,
    input  logic                              release_all_i,
    input  logic [ROWS-1:0]                   sel_n_i,
    output logic [COLS-1:0]                   col_n_o,
    output logic [ROWS*COLS-1:0]              lock_o,
    output logic [$clog2(ROWS*COLS+1)-1:0]    held_cnt_o,
    input  logic                              map_we_i,
    input  logic [CODE_W-1:0]                 map_addr_i,
    input  logic [entry_w(ROWS,COLS)-1:0]     map_data_i
);
    localparam int N  = ROWS * COLS;
    localparam int RW = clog2min1(ROWS);
    localparam int CW = clog2min1(COLS);
    localparam int EW = entry_w(ROWS, COLS);
    localparam int HW = $clog2(N + 1);
    localparam int VB = ent_valid_bit(ROWS, COLS);
    localparam int LB = ent_lock_bit(ROWS, COLS);
    localparam int RL = ent_row_lsb(COLS);

    logic              old_toggle_q;
    logic              s1_v_q, s1_pressed_q;
    logic [CODE_W-1:0] s1_code_q;
    logic              s2_v_q, s2_pressed_q;
    logic [EW-1:0]     rd_entry;
    logic [N-1:0]      key_q, lock_q, key_d, lock_d, eff;
    logic [COLS-1:0]   col_d;
    logic [HW-1:0]     cnt_d;
    logic [RW-1:0]     e_row;
    logic [CW-1:0]     e_col;
    logic              e_valid, e_lock, in_range, hit;
    int                idx;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // Track the live toggle so leaving reset raises no event.
            old_toggle_q <= ps2_key[10];
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
        end else begin
            old_toggle_q <= ps2_key[10];
            s1_v_q       <= (ps2_key[10] != old_toggle_q);
            s2_v_q       <= s1_v_q;
        end
        s1_pressed_q <= ps2_key[9];
        s1_code_q    <= CODE_W'(ps2_key[8:0]);
        s2_pressed_q <= s1_pressed_q;
    end

    kmx_map_ram #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .CODE_W    (CODE_W),
        .INIT_FILE (INIT_FILE)
    ) u_map (
        .clk_sys (clk_sys),
        .reset   (reset),
        .rd_addr (s1_code_q),
        .rd_data (rd_entry),
        .we      (map_we_i),
        .wr_addr (map_addr_i),
        .wr_data (map_data_i)
    );

    assign e_valid  = rd_entry[VB];
    assign e_lock   = rd_entry[LB];
    assign e_row    = rd_entry[RL +: RW];
    assign e_col    = rd_entry[ENT_COL_LSB +: CW];
    assign in_range = (int'(e_row) < ROWS) && (int'(e_col) < COLS);
    assign hit      = s2_v_q && e_valid && in_range;
    assign idx      = int'(e_row) * COLS + int'(e_col);

    always_comb begin
        key_d  = key_q;
        lock_d = lock_q;
        for (int i = 0; i < N; i++) begin
            if (hit && i == idx) begin
                if (e_lock) begin
                    if (s2_pressed_q) lock_d[i] = ~lock_q[i];
                end else begin
                    key_d[i] = s2_pressed_q;
                end
            end
        end
        // A coincident S2 press loses to release_all.
        if (release_all_i) key_d = '0;
    end

    assign eff = key_q | lock_q | ext_keys_i;

    always_comb begin
        col_d = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (eff[r*COLS + c] && !sel_n_i[r]) col_d[c] = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < N; i++) cnt_d = cnt_d + HW'(key_q[i] | lock_q[i]);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_q      <= '0;
            lock_q     <= '0;
            col_n_o    <= '1;
            held_cnt_o <= '0;
        end else begin
            key_q      <= key_d;
            lock_q     <= lock_d;
            col_n_o    <= col_d;
            held_cnt_o <= cnt_d;
        end
    end

    assign lock_o = lock_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// tb/tb_ps2_key_matrix.sv - self-checking bench for ps2_key_matrix
module tb_ps2_key_matrix;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic [63:0] ext_keys_i;
    logic        release_all_i;
    logic [7:0]  sel_n_i;
    logic [7:0]  col_n_o;
    logic [63:0] lock_o;
    logic [6:0]  held_cnt_o;
    logic        map_we_i;
    logic [8:0]  map_addr_i;
    logic [7:0]  map_data_i;

    ps2_key_matrix dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ps2_key       (ps2_key),
        .ext_keys_i    (ext_keys_i),
        .release_all_i (release_all_i),
        .sel_n_i       (sel_n_i),
        .col_n_o       (col_n_o),
        .lock_o        (lock_o),
        .held_cnt_o    (held_cnt_o),
        .map_we_i      (map_we_i),
        .map_addr_i    (map_addr_i),
        .map_data_i    (map_data_i)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [8:0]  code;
        logic        pressed;
        logic [7:0]  sel_n;
        logic [63:0] ext;
        logic [7:0]  col;
        logic [6:0]  held;
        logic        lock39;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] col;
        logic [6:0] held;
        logic       lock39;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic tog = 1'b0;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [8:0] code, input logic pressed);
        tog = ~tog;
        ps2_key = {tog, pressed, code};
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic pulse_release_all();
        release_all_i = 1'b1;
        tick();
        release_all_i = 1'b0;
        tick();
    endtask

    task automatic sb_pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got 0 entries want 1");
        end else begin
            e = sb.pop_front();
            check($sformatf("vec%0d_col", e.id), 64'(col_n_o), 64'(e.col));
            check($sformatf("vec%0d_held", e.id), 64'(held_cnt_o), 64'(e.held));
            check($sformatf("vec%0d_lock39", e.id), 64'(lock_o[39]), 64'(e.lock39));
        end
    endtask

    initial begin
        exp_t e;

        // Default map: 0x1C->(5,0), 0x1B->(5,1), CAPS->(4,7) lock, 0x07 unmapped.
        vecs[0]  = '{9'h01C, 1'b1, 8'hDF, 64'h0,   8'hFE, 7'd1, 1'b0};
        vecs[1]  = '{9'h01C, 1'b1, 8'hDF, 64'h0,   8'hFE, 7'd1, 1'b0};
        vecs[2]  = '{9'h01C, 1'b0, 8'hDF, 64'h0,   8'hFF, 7'd0, 1'b0};
        vecs[3]  = '{9'h058, 1'b1, 8'hEF, 64'h0,   8'h7F, 7'd1, 1'b1};
        vecs[4]  = '{9'h058, 1'b0, 8'hEF, 64'h0,   8'h7F, 7'd1, 1'b1};
        vecs[5]  = '{9'h007, 1'b1, 8'h00, 64'h0,   8'h7F, 7'd1, 1'b1};
        vecs[6]  = '{9'h058, 1'b1, 8'hEF, 64'h0,   8'hFF, 7'd0, 1'b0};
        vecs[7]  = '{9'h01C, 1'b1, 8'hDD, 64'h200, 8'hFC, 7'd1, 1'b0};
        vecs[8]  = '{9'h01C, 1'b0, 8'hDD, 64'h200, 8'hFD, 7'd0, 1'b0};
        vecs[9]  = '{9'h01B, 1'b1, 8'hDF, 64'h0,   8'hFD, 7'd1, 1'b0};
        vecs[10] = '{9'h01B, 1'b0, 8'hDF, 64'h0,   8'hFF, 7'd0, 1'b0};

        reset = 1'b1;
        ps2_key = 11'h0;
        ext_keys_i = '0;
        release_all_i = 1'b0;
        sel_n_i = 8'hFF;
        map_we_i = 1'b0;
        map_addr_i = '0;
        map_data_i = '0;
        ticks(3);
        reset = 1'b0;
        tick();
        check("rst_col", 64'(col_n_o), 64'hFF);
        check("rst_lock", lock_o, 64'h0);
        check("rst_held", 64'(held_cnt_o), 64'h0);

        // Exact latency: column drops on the third edge after the toggle edge.
        sel_n_i = 8'hDF;
        send(9'h01C, 1'b1);
        ticks(3);
        check("lat_early_col", 64'(col_n_o), 64'hFF);
        tick();
        check("lat_on_col", 64'(col_n_o), 64'hFE);
        check("lat_on_held", 64'(held_cnt_o), 64'd1);
        send(9'h01C, 1'b0);
        ticks(4);
        check("lat_off_col", 64'(col_n_o), 64'hFF);
        check("lat_off_held", 64'(held_cnt_o), 64'd0);

        // Table-driven single events through the scoreboard.
        for (int i = 0; i < 11; i++) begin
            sel_n_i = vecs[i].sel_n;
            ext_keys_i = vecs[i].ext;
            send(vecs[i].code, vecs[i].pressed);
            e.id = i;
            e.col = vecs[i].col;
            e.held = vecs[i].held;
            e.lock39 = vecs[i].lock39;
            sb.push_back(e);
            ticks(4);
            sb_pop_compare();
        end
        ext_keys_i = '0;

        // Lock survives release_all.
        sel_n_i = 8'hEF;
        send(9'h058, 1'b1);
        ticks(4);
        pulse_release_all();
        check("ra_lock39", 64'(lock_o[39]), 64'd1);
        check("ra_lock_held", 64'(held_cnt_o), 64'd1);
        check("ra_lock_col", 64'(col_n_o), 64'h7F);
        send(9'h058, 1'b1);
        ticks(4);
        check("lock_off", lock_o, 64'h0);

        // Back-to-back events on different keys.
        sel_n_i = 8'hDF;
        send(9'h01C, 1'b1);
        tick();
        send(9'h01B, 1'b1);
        ticks(3);
        check("b2b_first_col", 64'(col_n_o), 64'hFE);
        check("b2b_first_held", 64'(held_cnt_o), 64'd1);
        tick();
        check("b2b_both_col", 64'(col_n_o), 64'hFC);
        check("b2b_both_held", 64'(held_cnt_o), 64'd2);
        pulse_release_all();
        check("ra_col", 64'(col_n_o), 64'hFF);
        check("ra_held", 64'(held_cnt_o), 64'd0);

        // Press then release of the same key in consecutive cycles.
        send(9'h01C, 1'b1);
        tick();
        send(9'h01C, 1'b0);
        ticks(3);
        check("same_mid_col", 64'(col_n_o), 64'hFE);
        tick();
        check("same_end_col", 64'(col_n_o), 64'hFF);
        check("same_end_held", 64'(held_cnt_o), 64'd0);

        // release_all coincident with the S2 press.
        send(9'h01C, 1'b1);
        ticks(2);
        release_all_i = 1'b1;
        tick();
        release_all_i = 1'b0;
        ticks(2);
        check("ra_s2_col", 64'(col_n_o), 64'hFF);
        check("ra_s2_held", 64'(held_cnt_o), 64'd0);

        // External source only.
        sel_n_i = 8'hFD;
        ext_keys_i = 64'h200;
        tick();
        check("ext_col", 64'(col_n_o), 64'hFD);
        check("ext_held", 64'(held_cnt_o), 64'd0);
        ext_keys_i = '0;
        tick();
        check("ext_off_col", 64'(col_n_o), 64'hFF);

        // Reset with an event in flight.
        sel_n_i = 8'hDF;
        send(9'h01C, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ticks(4);
        check("rst_mid_col", 64'(col_n_o), 64'hFF);
        check("rst_mid_held", 64'(held_cnt_o), 64'd0);

`ifdef KMX_REMAP_EN
        // Remap written during the S1 read: old entry wins, new one next time.
        send(9'h01C, 1'b1);
        tick();
        map_we_i = 1'b1;
        map_addr_i = 9'h01C;
        map_data_i = {1'b1, 1'b0, 3'd2, 3'd3};
        tick();
        map_we_i = 1'b0;
        ticks(2);
        check("remap_old_col", 64'(col_n_o), 64'hFE);
        check("remap_old_held", 64'(held_cnt_o), 64'd1);
        pulse_release_all();
        sel_n_i = 8'hFB;
        send(9'h01C, 1'b1);
        ticks(4);
        check("remap_new_col", 64'(col_n_o), 64'hF7);
        check("remap_new_held", 64'(held_cnt_o), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
